// File: rtl/operand_entry.sv
// Calculator input stage: synchronizes switches, debounces ENTER/CLEAR and
// captures operand A, operand B and the operation select in sequence.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OP_W            = 3,
  parameter int DATA_W          = 5
) (
  input  logic              CLK_100MHz,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic [OP_W-1:0]   op_sw,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   sel0,
  output logic              valid,
  output logic [1:0]        step
);

  // state  | meaning
  // CAP_A  | waiting for ENTER to latch operand A
  // CAP_B  | waiting for ENTER to latch operand B
  // CAP_OP | waiting for ENTER to latch the operation select
  // SHOW   | all fields captured, valid high
  typedef enum logic [1:0] {
    CAP_A  = 2'd0,
    CAP_B  = 2'd1,
    CAP_OP = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] sw_s1, sw_s2;
  logic [OP_W-1:0]   op_s1, op_s2;
  logic [1:0]        btn_s1, btn_s2;
  logic [1:0]        deb, deb_q, blk, pulse, warm;
  logic [CNT_W-1:0]  cnt [2];

  state_t            state, state_nx;
  logic [DATA_W-1:0] a_nx, b_nx;
  logic [OP_W-1:0]   sel_nx;
  logic              valid_nx;

  // Bit 0 is ENTER, bit 1 is CLEAR. blk suppresses the pulse of a button
  // that was already held when reset released, until it is seen released.
  always_ff @(posedge CLK_100MHz) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      op_s1  <= '0;
      op_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb    <= '0;
      deb_q  <= '0;
      blk    <= 2'b11;
      pulse  <= '0;
      warm   <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      op_s1  <= op_sw;
      op_s2  <= op_s1;
      btn_s1 <= {btn_clear, btn_enter};
      btn_s2 <= btn_s1;
      warm   <= {warm[0], 1'b1};
      deb_q  <= deb;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TC) begin
          deb[i] <= btn_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (warm[1] && !btn_s2[i]) blk[i] <= 1'b0;
        pulse[i] <= deb[i] & ~deb_q[i] & ~blk[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a;
    b_nx     = b;
    sel_nx   = sel0;
    valid_nx = valid;
    if (pulse[1]) begin
      state_nx = CAP_A;
      a_nx     = '0;
      b_nx     = '0;
      sel_nx   = '0;
      valid_nx = 1'b0;
    end else if (pulse[0]) begin
      case (state)
        CAP_A: begin
          a_nx     = sw_s2;
          state_nx = CAP_B;
        end
        CAP_B: begin
          b_nx     = sw_s2;
          state_nx = CAP_OP;
        end
        CAP_OP: begin
          sel_nx   = op_s2;
          valid_nx = 1'b1;
          state_nx = SHOW;
        end
        SHOW: begin
          valid_nx = 1'b0;
          state_nx = CAP_A;
        end
        default: state_nx = CAP_A;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!rst_n) begin
      state <= CAP_A;
      a     <= '0;
      b     <= '0;
      sel0  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      a     <= a_nx;
      b     <= b_nx;
      sel0  <= sel_nx;
      valid <= valid_nx;
    end
  end

  assign step = state;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry with a short debounce: table of capture steps
// checked through an expectation queue, plus hand-built timing sequences.
module tb_operand_entry;

  logic       clk;
  logic       rst_n;
  logic [4:0] sw;
  logic [2:0] op_sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [4:0] a;
  logic [4:0] b;
  logic [2:0] sel0;
  logic       valid;
  logic [1:0] step;

  int checks = 0;
  int errors = 0;
  int enter_cnt = 0;
  int both_cnt = 0;

  typedef struct {
    logic [4:0] sw;
    logic [2:0] op;
    logic       enter;
    logic       clear;
    logic [4:0] ea;
    logic [4:0] eb;
    logic [2:0] esel;
    logic       evalid;
    logic [1:0] estep;
  } vec_t;

  vec_t tbl [13];
  vec_t exp_q [$];

  operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .OP_W(3),
    .DATA_W(5)
  ) dut (
    .CLK_100MHz(clk),
    .rst_n(rst_n),
    .sw(sw),
    .op_sw(op_sw),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .a(a),
    .b(b),
    .sel0(sel0),
    .valid(valid),
    .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.pulse[0] === 1'b1) enter_cnt++;
    if (dut.pulse[0] === 1'b1 && dut.pulse[1] === 1'b1) both_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    check({tag, ".a"}, 32'(a), 32'(e.ea));
    check({tag, ".b"}, 32'(b), 32'(e.eb));
    check({tag, ".sel0"}, 32'(sel0), 32'(e.esel));
    check({tag, ".valid"}, 32'(valid), 32'(e.evalid));
    check({tag, ".step"}, 32'(step), 32'(e.estep));
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    vec_t e;
    v = tbl[i];
    sw = v.sw;
    op_sw = v.op;
    exp_q.push_back(v);
    cyc(3);
    if (v.enter || v.clear) begin
      btn_enter = v.enter;
      btn_clear = v.clear;
      cyc(10);
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      cyc(8);
    end else begin
      cyc(18);
    end
    e = exp_q.pop_front();
    check_outs($sformatf("vec%0d", i), e);
  endtask

  initial begin
    int base;
    int early;
    logic [1:0] pat [5];
    vec_t z;

    //            sw     op    E     C     a      b      sel   v     step
    tbl[0]  = '{5'd22, 3'd0, 1'b1, 1'b0, 5'd13, 5'd22, 3'd0, 1'b0, 2'd2};
    tbl[1]  = '{5'd22, 3'd5, 1'b1, 1'b0, 5'd13, 5'd22, 3'd5, 1'b1, 2'd3};
    tbl[2]  = '{5'd31, 3'd5, 1'b0, 1'b0, 5'd13, 5'd22, 3'd5, 1'b1, 2'd3};
    tbl[3]  = '{5'd0,  3'd5, 1'b1, 1'b0, 5'd0,  5'd22, 3'd5, 1'b0, 2'd1};
    tbl[4]  = '{5'd0,  3'd5, 1'b0, 1'b1, 5'd0,  5'd0,  3'd0, 1'b0, 2'd0};
    tbl[5]  = '{5'd7,  3'd5, 1'b1, 1'b0, 5'd7,  5'd0,  3'd0, 1'b0, 2'd1};
    tbl[6]  = '{5'd9,  3'd5, 1'b1, 1'b0, 5'd7,  5'd9,  3'd0, 1'b0, 2'd2};
    tbl[7]  = '{5'd9,  3'd6, 1'b1, 1'b1, 5'd0,  5'd0,  3'd0, 1'b0, 2'd0};
    tbl[8]  = '{5'd31, 3'd6, 1'b1, 1'b0, 5'd31, 5'd0,  3'd0, 1'b0, 2'd1};
    tbl[9]  = '{5'd31, 3'd6, 1'b1, 1'b0, 5'd31, 5'd31, 3'd0, 1'b0, 2'd2};
    tbl[10] = '{5'd31, 3'd7, 1'b1, 1'b0, 5'd31, 5'd31, 3'd7, 1'b1, 2'd3};
    tbl[11] = '{5'd31, 3'd7, 1'b0, 1'b1, 5'd0,  5'd0,  3'd0, 1'b0, 2'd0};
    tbl[12] = '{5'd3,  3'd7, 1'b1, 1'b0, 5'd3,  5'd0,  3'd0, 1'b0, 2'd1};
    z = '{5'd0, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0, 1'b0, 2'd0};

    rst_n = 1'b0;
    sw = 5'd0;
    op_sw = 3'd0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    cyc(3);
    check_outs("reset", z);
    rst_n = 1'b1;
    cyc(4);

    // ENTER held 20 cycles: single pulse after edge k+6, capture at k+7
    sw = 5'd13;
    cyc(3);
    btn_enter = 1'b1;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (dut.pulse[0] !== 1'b0) early++;
    end
    check("first.no_early_pulse", 32'(early), 32'd0);
    cyc(1);
    check("first.pulse_k6", 32'(dut.pulse[0]), 32'd1);
    check("first.step_k6", 32'(step), 32'd0);
    cyc(1);
    check("first.pulse_k7", 32'(dut.pulse[0]), 32'd0);
    check("first.step_k7", 32'(step), 32'd1);
    check("first.a", 32'(a), 32'd13);
    cyc(12);
    btn_enter = 1'b0;
    cyc(8);
    check("first.pulse_count", 32'(enter_cnt), 32'd1);
    check("first.step_hold", 32'(step), 32'd1);

    for (int i = 0; i <= 2; i++) apply_vec(i);

    // bouncing ENTER in SHOW, then a steady press
    base = enter_cnt;
    pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd1; pat[3] = 2'd1; pat[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      btn_enter = pat[i][0];
      cyc(1);
    end
    btn_enter = 1'b1;
    cyc(6);
    check("bounce.no_early_pulse", 32'(enter_cnt), 32'(base));
    check("bounce.step_before", 32'(step), 32'd3);
    cyc(2);
    check("bounce.one_pulse", 32'(enter_cnt), 32'(base + 1));
    check("bounce.step", 32'(step), 32'd0);
    check("bounce.valid", 32'(valid), 32'd0);
    check("bounce.a_kept", 32'(a), 32'd13);
    cyc(6);
    btn_enter = 1'b0;
    cyc(8);
    check("bounce.no_second_pulse", 32'(enter_cnt), 32'(base + 1));

    for (int i = 3; i <= 6; i++) apply_vec(i);
    base = both_cnt;
    apply_vec(7);
    check("coincide.pulses_together", 32'(both_cnt), 32'(base + 1));
    for (int i = 8; i <= 12; i++) apply_vec(i);

    // one-edge reset in CAP_B while ENTER is mid-debounce
    base = enter_cnt;
    btn_enter = 1'b1;
    cyc(4);
    check("rst.cnt_mid", 32'(dut.cnt[0]), 32'd2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check_outs("rst", z);
    cyc(15);
    check("rst.held_no_pulse", 32'(enter_cnt), 32'(base));
    check("rst.held_step", 32'(step), 32'd0);
    btn_enter = 1'b0;
    cyc(8);
    sw = 5'd17;
    cyc(3);
    btn_enter = 1'b1;
    cyc(10);
    btn_enter = 1'b0;
    cyc(8);
    check("rst.repress_pulse", 32'(enter_cnt), 32'(base + 1));
    check("rst.repress_step", 32'(step), 32'd1);
    check("rst.repress_a", 32'(a), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
